// File: rtl/uabc_uart_tx.sv
// 8N1 serial transmitter with a one-byte holding register in front of the frame shifter.
// Accepts bytes on a valid/ready handshake and sends them LSB first, back to back when a byte is waiting.
//
// state | meaning
// IDLE  | line high, waiting for a held byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); reloads straight into START if a byte is held
module uabc_uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       hold_data;
  logic             hold_full;
  logic [7:0]       shift;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic             bit_end;
  logic             reload;

  assign tx_ready = !hold_full && !rst;
  assign busy     = (state != IDLE) || hold_full;
  assign bit_end  = (baud_cnt == div_lat);
  // Reload only ever happens with the holding register full, so it never races an accept.
  assign reload   = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      div_lat   <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
    end else begin
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (reload) begin
        shift     <= hold_data;
        hold_full <= 1'b0;
        div_lat   <= baud_div;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        tx        <= 1'b0;
        state     <= START;
      end else begin
        unique case (state)
          IDLE: begin
            tx       <= 1'b1;
            baud_cnt <= '0;
          end
          START: begin
            if (bit_end) begin
              baud_cnt <= '0;
              tx       <= shift[0];
              state    <= DATA;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == 3'd7) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {1'b0, shift[7:1]};
                tx      <= shift[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              tx       <= 1'b1;
              state    <= IDLE;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uabc_uart_tx.md
UABC_UART_TX -- requirements
Module: uabc_uart_tx

Interface
REQ-001 Parameter: DIV_W, default 16, width of the baud divisor.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: baud_div  input  DIV_W  bit period minus one, in clk cycles.
REQ-005 Port: tx_data  input  8  byte to transmit.
REQ-006 Port: tx_valid  input  1  tx_data is valid.
REQ-007 Port: tx_ready  output  1  block can accept a byte this cycle.
REQ-008 Port: tx  output  1  serial line, 8N1, idle high.
REQ-009 Port: busy  output  1  a frame is in progress or a byte is held.

Function
REQ-010 The block SHALL be the serial output stage downstream of the project core: it accepts bytes on a valid/ready handshake and serializes them as 8N1 frames on tx.
REQ-011 The block SHALL contain a one-byte holding register and a frame shift register, so one byte can wait while another is being sent.
REQ-012 A transfer SHALL occur on a rising edge where tx_valid and tx_ready are both 1; tx_data is captured into the holding register.
REQ-013 tx_ready SHALL equal (holding register empty) AND NOT rst, combinationally.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; if the holding register is full, the next edge SHALL move the byte to the shift register, empty the holding register, latch baud_div, clear the bit counter and enter START.
REQ-016 START: tx=0 for (baud_div_latched+1) cycles, then DATA.
REQ-017 DATA: tx=shift[0] (LSB first); 8 bits, each (baud_div_latched+1) cycles, then STOP.
REQ-018 STOP: tx=1 for (baud_div_latched+1) cycles. At the end of STOP, if the holding register is full, the block SHALL reload, relatch baud_div and go straight to START with zero idle cycles. Otherwise it SHALL go to IDLE.
REQ-019 Frame length SHALL be exactly 10*(baud_div+1) cycles. baud_div=0 gives a 1-cycle bit period.
REQ-020 Latency: the byte is accepted at edge E0 with the FSM in IDLE. The reload occurs at E0+1, and tx SHALL be low starting from the cycle after E0+1.
REQ-021 Changes to baud_div during a frame SHALL have no effect until the next reload.
REQ-022 A byte can be accepted in the same cycle the holding register is reloaded into the shift register only if tx_ready was already 1. No byte SHALL ever be overwritten or dropped.
REQ-023 busy SHALL be 1 when the state is not IDLE or the holding register is full.
REQ-024 The baud counter and bit counter SHALL never wrap mid-bit. The baud counter SHALL count from 0 to baud_div_latched and then reset to 0.

Reset
REQ-025 While rst=1, at each edge the block SHALL force state=IDLE, tx=1, holding register empty, counters=0 and busy=0; tx_ready SHALL be 0 while rst=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, and any held byte is discarded.
REQ-027 On the first cycle after rst deasserts, tx_ready SHALL be 1 and tx SHALL be 1.

Verification
REQ-028 baud_div=3, send 0xA5 once -> tx=0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total; busy falls after the final stop cycle.
REQ-029 baud_div=0, tx_valid held high with 0x00 then 0xFF -> two back-to-back 10-cycle frames with no idle gap; tx_ready is low while the second byte is held.
REQ-030 baud_div=2, tx_valid held high for 3 bytes -> third byte accepted only after the first frame's reload; every byte is sent in order and none is lost.
REQ-031 baud_div=3, change baud_div to 7 during DATA -> current frame stays at 4 cycles per bit; the next frame uses 8 cycles per bit.
REQ-032 Assert rst for 1 cycle during bit 4 of frame 0x3C with a byte held -> tx=1 and busy=0 on the next cycle; the held byte is never transmitted; tx_ready=1 after release.
